// File: rtl/clut_cache_ctrl_pkg.sv
// Shared definitions for the CLUT cache controller: FSM states, texture
// format codes, VRAM address width, CLUT geometry and the palette tag.
package clut_cache_ctrl_pkg;

  localparam int VRAM_ADR_W   = 18;
  localparam int CLUT_ENTRIES = 256;
  localparam int CLUT_ENTRY_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } clut_state_t;

  typedef enum logic [1:0] {
    TEX_4BIT  = 2'd0,
    TEX_8BIT  = 2'd1,
    TEX_16BIT = 2'd2,
    TEX_RSVD  = 2'd3
  } tex_fmt_t;

  typedef struct packed {
    logic       valid;
    logic [5:0] x;
    logic [8:0] y;
    logic       is8bit;
  } clut_tag_t;

  // VRAM word address of a 16-pixel CLUT block: Y*512 + X16*8.
  function automatic logic [VRAM_ADR_W-1:0] burst_adr(input logic [8:0] y,
                                                      input logic [5:0] x16);
    return {y, x16, 3'b000};
  endfunction

endpackage

// File: rtl/clut_cache_ctrl_if.sv
// Bus bundle of the CLUT cache controller: load request, VRAM burst read
// and the two lookup ports. The snoop inputs exist only when
// CLUT_SNOOP_INVALIDATE_EN is defined.
interface clut_cache_ctrl_if;

  logic        i_loadReq;
  logic [5:0]  i_clutX;
  logic [8:0]  i_clutY;
  logic        i_is8bit;
  logic        o_busy;
  logic        o_loadDone;
  logic        o_memReq;
  logic [17:0] o_memAdr;
  logic        i_memAck;
  logic        i_memDataValid;
  logic [31:0] i_memData;
  logic        i_lookupValidA;
  logic [7:0]  i_indexA;
  logic [15:0] o_clutA;
  logic        i_lookupValidB;
  logic [7:0]  i_indexB;
  logic [15:0] o_clutB;
`ifdef CLUT_SNOOP_INVALIDATE_EN
  logic        i_vramWrValid;
  logic [8:0]  i_vramWrY;
  logic [5:0]  i_vramWrX16;
`endif

  // Requester / memory / texel-unit side.
  modport master (
`ifdef CLUT_SNOOP_INVALIDATE_EN
    output i_vramWrValid, i_vramWrY, i_vramWrX16,
`endif
    output i_loadReq, i_clutX, i_clutY, i_is8bit,
    output i_memAck, i_memDataValid, i_memData,
    output i_lookupValidA, i_indexA, i_lookupValidB, i_indexB,
    input  o_busy, o_loadDone, o_memReq, o_memAdr, o_clutA, o_clutB
  );

  // Cache controller side.
  modport slave (
`ifdef CLUT_SNOOP_INVALIDATE_EN
    input  i_vramWrValid, i_vramWrY, i_vramWrX16,
`endif
    input  i_loadReq, i_clutX, i_clutY, i_is8bit,
    input  i_memAck, i_memDataValid, i_memData,
    input  i_lookupValidA, i_indexA, i_lookupValidB, i_indexB,
    output o_busy, o_loadDone, o_memReq, o_memAdr, o_clutA, o_clutB
  );

endinterface

// File: rtl/clut_ram_2r1w.sv
// 256x16 CLUT storage. Stored as 128 pairs so one VRAM beat (two pixels)
// lands in a single write; two independent registered read ports.
import clut_cache_ctrl_pkg::*;

module clut_ram_2r1w (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [6:0]  wr_adr,
  input  logic [31:0] wr_data,
  input  logic        re_a,
  input  logic [7:0]  adr_a,
  input  logic        re_b,
  input  logic [7:0]  adr_b,
  output logic [15:0] rd_a,
  output logic [15:0] rd_b
);

  logic [31:0] mem [CLUT_ENTRIES/2];
  logic [31:0] word_a;
  logic [31:0] word_b;

  assign word_a = mem[adr_a[7:1]];
  assign word_b = mem[adr_b[7:1]];

  // Pair write: even entry in the low half, odd entry in the high half.
  // NOTE: the array has no reset so it maps onto RAM macros; contents are
  // only meaningful once a load has written them.
  always_ff @(posedge clk) begin
    if (we) mem[wr_adr] <= wr_data;
  end

  // Registered reads, holding when the port enable is low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      if (re_a) rd_a <= adr_a[0] ? word_a[31:16] : word_a[15:0];
      if (re_b) rd_b <= adr_b[0] ? word_b[31:16] : word_b[15:0];
    end
  end

endmodule

// File: rtl/clut_cache_ctrl.sv
// CLUT cache controller: tag compare on palette-load requests, 8-word VRAM
// burst refill on a miss, and dual-port palette lookup.
// Optional feature: CLUT_SNOOP_INVALIDATE_EN adds VRAM write snooping that
// invalidates the resident palette when it is overwritten.
import clut_cache_ctrl_pkg::*;

module clut_cache_ctrl #(
  parameter int BURST_WORDS = 8  // only 8 is supported (16 entries per burst)
) (
  input  logic            clk,
  input  logic            i_nRst,
  clut_cache_ctrl_if.slave bus
);

  clut_state_t           state;
  clut_tag_t             tag;
  logic [3:0]            blk;
  logic [3:0]            last_blk;
  logic [3:0]            blk_inc;
  logic [2:0]            beat;
  logic                  busy;
  logic                  load_done;
  logic                  mem_req;
  logic [VRAM_ADR_W-1:0] mem_adr;
  logic                  snoop_dirty;
  logic                  snoop_hit;
  logic                  hit;
  logic                  beat_we;
  logic                  last_beat;

  // A resident 256-entry palette also serves a 16-entry request at its origin.
  assign hit = tag.valid && (tag.x == bus.i_clutX) && (tag.y == bus.i_clutY) &&
               (tag.is8bit || !bus.i_is8bit);
  assign beat_we   = (state == ST_RECV) && bus.i_memDataValid;
  assign last_beat = beat_we && (beat == 3'(BURST_WORDS - 1));
  assign blk_inc   = blk + 4'd1;

`ifdef CLUT_SNOOP_INVALIDATE_EN
  logic [5:0] snoop_dx;
  // Write falls inside the cached span (1 or 16 blocks, wrapping in X).
  assign snoop_dx  = bus.i_vramWrX16 - tag.x;
  assign snoop_hit = bus.i_vramWrValid && (bus.i_vramWrY == tag.y) &&
                     (tag.is8bit ? (snoop_dx[5:4] == 2'b00) : (snoop_dx == 6'd0));
`else
  assign snoop_hit = 1'b0;
`endif

  // Load FSM with registered handshake outputs and tag maintenance.
  always_ff @(posedge clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state       <= ST_IDLE;
      tag         <= '0;
      blk         <= '0;
      last_blk    <= '0;
      beat        <= '0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      mem_req     <= 1'b0;
      mem_adr     <= '0;
      snoop_dirty <= 1'b0;
    end else begin
      load_done <= 1'b0;
      // Snoop: drop a valid tag; remember hits on a palette still loading.
      if (snoop_hit) begin
        tag.valid <= 1'b0;
        if (busy) snoop_dirty <= 1'b1;
      end
      case (state)
        // DONE is the idle cycle after completion; busy is already low so a
        // request arriving here is accepted exactly as in IDLE.
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (bus.i_loadReq) begin
            if (hit) begin
              load_done <= 1'b1;
            end else begin
              tag         <= '{valid: 1'b0, x: bus.i_clutX, y: bus.i_clutY,
                               is8bit: bus.i_is8bit};
              last_blk    <= bus.i_is8bit ? 4'd15 : 4'd0;
              blk         <= '0;
              busy        <= 1'b1;
              mem_req     <= 1'b1;
              mem_adr     <= burst_adr(bus.i_clutY, bus.i_clutX);
              snoop_dirty <= 1'b0;
              state       <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.i_memAck) begin
            mem_req <= 1'b0;
            beat    <= '0;
            state   <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (beat_we) begin
            beat <= beat + 3'd1;
            if (last_beat) begin
              if (blk == last_blk) begin
                // Completion is signalled right after the final beat.
                tag.valid <= !(snoop_dirty || snoop_hit);
                load_done <= 1'b1;
                busy      <= 1'b0;
                state     <= ST_DONE;
              end else begin
                // X advances within the same VRAM line; never carries into Y.
                blk     <= blk_inc;
                mem_req <= 1'b1;
                mem_adr <= burst_adr(tag.y, tag.x + {2'b00, blk_inc});
                state   <= ST_REQ;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy     = busy;
  assign bus.o_loadDone = load_done;
  assign bus.o_memReq   = mem_req;
  assign bus.o_memAdr   = mem_adr;

  // Lookups are gated by busy, so a refill write never races a read.
  clut_ram_2r1w u_ram (
    .clk     (clk),
    .rst_n   (i_nRst),
    .we      (beat_we),
    .wr_adr  ({blk, beat}),
    .wr_data (bus.i_memData),
    .re_a    (bus.i_lookupValidA && !busy),
    .adr_a   (bus.i_indexA),
    .re_b    (bus.i_lookupValidB && !busy),
    .adr_b   (bus.i_indexB),
    .rd_a    (bus.o_clutA),
    .rd_b    (bus.o_clutB)
  );

endmodule

// File: doc/clut_cache_ctrl.md
Name: clut_cache_ctrl

Overview:
- Owns the 256x16 CLUT cache that feeds the palette lookups of both texel converters in dual-pixel mode. It has two read ports, A and B, each with 1-cycle latency.
- On a palette-load request it compares a tag against the cached palette. On a miss it fetches the palette from VRAM in 8-word bursts.
- It sits between the primitive setup logic (load request), the VRAM memory arbiter (burst read) and the two texel-to-RGB units (index lookup).

Parameters:
- BURST_WORDS, 8, 32-bit words per VRAM burst (16 CLUT entries per burst). Only 8 is supported.

Ports:
- clk  in  1  system clock
- i_nRst  in  1  asynchronous active-low reset
- i_loadReq  in  1  one-cycle pulse: make the palette at (i_clutX, i_clutY) resident
- i_clutX  in  6  CLUT X position in units of 16 pixels
- i_clutY  in  9  CLUT Y line
- i_is8bit  in  1  1 = 256-entry palette, 0 = 16-entry palette
- o_busy  out  1  load in progress; lookups are stalled
- o_loadDone  out  1  one-cycle pulse when the palette is resident
- o_memReq  out  1  VRAM burst request, held until acknowledged
- o_memAdr  out  18  VRAM word address of the burst (Y*512 + pixelX/2)
- i_memAck  in  1  burst accepted (one-cycle pulse)
- i_memDataValid  in  1  data beat valid
- i_memData  in  32  data beat: [15:0] even pixel, [31:16] odd pixel
- i_lookupValidA  in  1  port A lookup valid
- i_indexA  in  8  port A palette index
- o_clutA  out  16  port A colour, 1 cycle after the lookup
- i_lookupValidB  in  1  port B lookup valid
- i_indexB  in  8  port B palette index
- o_clutB  out  16  port B colour, 1 cycle after the lookup

Behaviour:
- Reset values:
  - o_busy=0, o_loadDone=0, o_memReq=0, o_memAdr=0, o_clutA=0, o_clutB=0.
  - Tag invalid.
  - State IDLE; beat and block counters 0.
  - The CLUT RAM contents are not reset.
- Tag = {valid, X, Y, is8bit}.
  - Hit: valid and X and Y match, and (stored is8bit OR !i_is8bit).
  - A resident 256-entry palette therefore also serves 16-entry requests at the same origin.
- State machine IDLE -> REQ -> RECV -> (REQ | DONE) -> IDLE.
  - IDLE:
    - i_loadReq and hit: o_loadDone=1 on the next cycle; no memory traffic; o_busy stays 0.
    - i_loadReq and miss: latch the tag with valid=0, blocks = is8bit ? 16 : 1, block counter = 0, go to REQ, o_busy=1.
  - REQ:
    - o_memReq=1.
    - o_memAdr = {Y, (X+blk) mod 64, 3'b000}. X wraps within the same line; it never carries into Y.
    - On i_memAck: drop o_memReq the same edge, go to RECV, beat counter = 0.
  - RECV:
    - Each i_memDataValid beat b of block k writes entry {k,b,0} <= i_memData[15:0] and entry {k,b,1} <= i_memData[31:16].
    - After beat 7: if k is the last block go to DONE, else increment k and go to REQ.
    - Gaps between beats are allowed.
    - i_memDataValid outside RECV is ignored.
  - DONE: set tag valid=1, pulse o_loadDone for one cycle, o_busy=0, go to IDLE.
- o_loadDone asserts exactly 1 cycle after the trigger on a hit, and 1 cycle after the final beat on a miss.
- i_loadReq while o_busy=1 is ignored. The requester must wait for o_loadDone.
- Lookups:
  - o_clutA/B are registered reads of the RAM, updated only when the respective valid is high.
  - Otherwise they hold their value.
  - Both ports read independently in the same cycle (2R1W).
  - Lookups while o_busy=1 are not serviced; outputs hold. Callers stall on o_busy.
- A RAM write and a lookup of the same index in the same cycle cannot occur (busy gating). No bypass is required.
- i_nRst asserted mid-load:
  - Immediate abort; outputs go to reset values.
  - Tag invalid, so the next request reloads.
  - Partial RAM data is irrelevant.

Optional Feature:
- Macro: CLUT_SNOOP_INVALIDATE_EN.
- When defined, extra inputs i_vramWrValid (1), i_vramWrY (9) and i_vramWrX16 (6, pixel X/16) are present.
- A write clears the tag valid bit the next cycle when all of the following hold:
  - the tag is valid, and
  - Y matches, and
  - (X16 - tagX) mod 64 < (is8bit ? 16 : 1).
- A snoop hit during a load forces the tag to stay invalid after DONE; o_loadDone still pulses.
- Undefined: the ports are absent and the tag is only replaced by loads.

Decomposition:
- Shared GPU package:
  - state encoding (IDLE/REQ/RECV/DONE);
  - the texture format constants (4-bit=0, 8-bit=1, 16-bit=2, reserved=3);
  - the VRAM word-address width (18);
  - the CLUT entry count (256).
- One sub-module, clut_ram_2r1w: 256x16, one synchronous write port and two registered read ports with per-port enable.

Test Plan:
- 4-bit miss:
  - Stimulus: load X=3, Y=480; 8 beats, beat0=0x7FFF0001.
  - Required: o_memAdr=480*512+24; entry0=0x0001, entry1=0x7FFF; o_loadDone 1 cycle after beat 7.
- Hit:
  - Stimulus: repeat the same request.
  - Required: o_loadDone next cycle; o_memReq never asserts; o_busy stays 0.
- 8-bit wrap:
  - Stimulus: load X=60, Y=5, 8-bit.
  - Required: 16 bursts; the fifth burst address is 5*512+0 (X wrapped to 0); entries 64..79 come from that burst.
- Dual lookup:
  - Stimulus: after load, A=0x00 and B=0xFF in the same cycle.
  - Required: both colours correct 1 cycle later; outputs hold when valid is low; lookups during busy are ignored.
- Reset during RECV:
  - Stimulus: assert i_nRst low after beat 3.
  - Required: outputs at reset values; a subsequent identical request misses and reloads.
- Snoop (CLUT_SNOOP_INVALIDATE_EN):
  - Stimulus: after a valid 8-bit load at X=2, write at Y match, X16=17.
  - Required: the next request misses.
  - Stimulus: write at X16=18.
  - Required: no invalidate.
